// File: rtl/axi_waveform_buffer_pkg.sv
// Shared definitions for the waveform buffer: state encoding, sample width, default address width.
// Optional looped playback is selected with the WFRM_LOOP_EN macro.
package axi_waveform_buffer_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

endpackage

// File: rtl/axi_waveform_buffer_skid_fifo.sv
// Two-entry AXI-Stream output FIFO with synchronous flush; head entry drives the outputs so
// data stays stable while the consumer stalls.
module wfrm_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   cnt
);

  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push) begin
        ent_d[wptr_q] = din;
        wptr_d        = ~wptr_q;
      end
      if (pop) rptr_d = ~rptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout  = ent_q[rptr_q];
  assign valid = (cnt_q != 2'd0);
  assign cnt   = cnt_q;

endmodule

// File: rtl/axi_waveform_buffer.sv
// Stored-waveform buffer: sample-wise load into block RAM, AXI-Stream playback with backpressure.
// Define WFRM_LOOP_EN to add loop_cnt (waveform replayed loop_cnt+1 times per play request).
module axi_waveform_buffer
  import axi_waveform_buffer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              axi_tclk,
  input  logic              axi_treset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_err,
  input  logic              play_req,
  input  logic              abort,
`ifdef WFRM_LOOP_EN
  input  logic [7:0]        loop_cnt,
`endif
  output logic              wf_read_ready,
  output logic [ADDR_W:0]   wf_len,
  output logic              playing,
  output logic              play_done,
  output logic [DATA_W-1:0] wfrm_axis_tdata,
  output logic              wfrm_axis_tvalid,
  output logic              wfrm_axis_tlast,
  input  logic              wfrm_axis_tready,
  output logic [1:0]        dbg_state
);

  localparam int LW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wf_len_q, wf_len_d;
  logic              wr_err_q, wr_err_d;
  logic              play_done_q, play_done_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]        loops_q, loops_d;
  logic              issued_all_q, issued_all_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok, start, pop, end_hs, abort_now, issue, at_end;
  logic [ADDR_W-1:0] cur_idx;
  logic [7:0]        cur_loops, loop_in;
  logic [2:0]        occ;
  logic [DATA_W:0]   fifo_dout;
  logic              fifo_valid;
  logic [1:0]        fifo_cnt;

`ifdef WFRM_LOOP_EN
  assign loop_in = loop_cnt;
`else
  assign loop_in = 8'd0;
`endif

  // A play request in READY wins over a coincident write.
  assign wr_ok = wr_en && ((state_q == ST_EMPTY) || (state_q == ST_LOAD) ||
                           ((state_q == ST_READY) && !play_req));
  assign start     = (state_q == ST_READY) && play_req;
  assign pop       = fifo_valid && wfrm_axis_tready;
  assign end_hs    = (state_q == ST_PLAY) && pop && fifo_dout[DATA_W];
  assign abort_now = (state_q == ST_PLAY) && abort && !end_hs;

  // Slots committed after this cycle's pop; keeps FIFO + in-flight read within two entries.
  assign occ   = {1'b0, fifo_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue = start || ((state_q == ST_PLAY) && !issued_all_q && (occ < 3'd2) &&
                           !abort_now && !end_hs);

  assign cur_idx   = start ? '0 : rd_idx_q;
  assign cur_loops = start ? loop_in : loops_q;
  assign at_end    = ({1'b0, cur_idx} == (wf_len_q - LW'(1)));

  always_comb begin
    state_d      = state_q;
    wf_len_d     = wf_len_q;
    wr_err_d     = wr_en && !wr_ok;
    play_done_d  = 1'b0;
    rd_idx_d     = rd_idx_q;
    loops_d      = loops_q;
    issued_all_d = start ? 1'b0 : issued_all_q;
    rd_pend_d    = issue;
    rd_last_d    = issue && at_end && (cur_loops == 8'd0);

    if (issue) begin
      if (at_end) begin
        rd_idx_d = '0;
        if (cur_loops == 8'd0) begin
          issued_all_d = 1'b1;
          loops_d      = 8'd0;
        end else begin
          loops_d = cur_loops - 8'd1;
        end
      end else begin
        rd_idx_d = cur_idx + 1'b1;
        loops_d  = cur_loops;
      end
    end

    case (state_q)
      ST_EMPTY, ST_LOAD, ST_READY: begin
        if (start) begin
          state_d = ST_PLAY;
        end else if (wr_ok) begin
          if (wr_last) begin
            state_d  = ST_READY;
            wf_len_d = LW'(wr_addr) + LW'(1);
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_PLAY: begin
        if (end_hs || abort_now) begin
          state_d     = ST_READY;
          play_done_d = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      state_q      <= ST_EMPTY;
      wf_len_q     <= '0;
      wr_err_q     <= 1'b0;
      play_done_q  <= 1'b0;
      rd_idx_q     <= '0;
      loops_q      <= 8'd0;
      issued_all_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wf_len_q     <= wf_len_d;
      wr_err_q     <= wr_err_d;
      play_done_q  <= play_done_d;
      rd_idx_q     <= rd_idx_d;
      loops_q      <= loops_d;
      issued_all_q <= issued_all_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
    end
  end

  // Sample RAM with registered read port; contents survive reset.
  always_ff @(posedge axi_tclk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (issue) rd_data_q <= mem[cur_idx];
  end

  wfrm_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (axi_tclk),
    .rst   (axi_treset),
    .push  (rd_pend_q),
    .din   ({rd_last_q, rd_data_q}),
    .pop   (pop),
    .flush (abort_now),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .cnt   (fifo_cnt)
  );

  assign wfrm_axis_tdata  = fifo_dout[DATA_W-1:0];
  assign wfrm_axis_tlast  = fifo_dout[DATA_W];
  assign wfrm_axis_tvalid = fifo_valid;
  assign wr_err           = wr_err_q;
  assign play_done        = play_done_q;
  assign wf_len           = wf_len_q;
  assign wf_read_ready    = (state_q == ST_READY);
  assign playing          = (state_q == ST_PLAY);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_axi_waveform_buffer.sv
// Randomized bench for axi_waveform_buffer against a sample-list reference model.
// Build with +define+WFRM_LOOP_EN to also exercise looped playback.
module tb_axi_waveform_buffer;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W      = 33;

  logic              axi_tclk = 1'b0;
  logic              axi_treset;
  logic              wr_en, wr_last, play_req, abort;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [7:0]        loop_cnt;
  logic              wr_err, wf_read_ready, playing, play_done;
  logic [ADDR_W:0]   wf_len;
  logic [31:0]       wfrm_axis_tdata;
  logic              wfrm_axis_tvalid, wfrm_axis_tlast, wfrm_axis_tready;
  logic [1:0]        dbg_state;

  logic [31:0]  ref_mem [DEPTH];
  int           ref_len;
  logic [W-1:0] exp_q [$];
  int           n_cmp = 0;
  int           n_err = 0;

  axi_waveform_buffer #(.ADDR_W(ADDR_W)) dut (
    .axi_tclk         (axi_tclk),
    .axi_treset       (axi_treset),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_last          (wr_last),
    .wr_err           (wr_err),
    .play_req         (play_req),
    .abort            (abort),
`ifdef WFRM_LOOP_EN
    .loop_cnt         (loop_cnt),
`endif
    .wf_read_ready    (wf_read_ready),
    .wf_len           (wf_len),
    .playing          (playing),
    .play_done        (play_done),
    .wfrm_axis_tdata  (wfrm_axis_tdata),
    .wfrm_axis_tvalid (wfrm_axis_tvalid),
    .wfrm_axis_tlast  (wfrm_axis_tlast),
    .wfrm_axis_tready (wfrm_axis_tready),
    .dbg_state        (dbg_state)
  );

  always #5 axi_tclk = ~axi_tclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected packet: the stored samples in order, repeated lp+1 times, tlast on the very end.
  task automatic build_expect(input int lp);
    exp_q.delete();
    for (int p = 0; p <= lp; p++)
      for (int i = 0; i < ref_len; i++)
        exp_q.push_back({(p == lp) && (i == ref_len - 1), ref_mem[i]});
  endtask

  task automatic load_wave(input int len, input bit ramp);
    logic [31:0] d;
    for (int i = 0; i < len; i++) begin
      d = ramp ? 32'h1000_0000 + 32'(i) : $urandom;
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = d; wr_last = (i == len - 1);
      ref_mem[i] = d;
      @(negedge axi_tclk);
      wr_en = 1'b0; wr_last = 1'b0;
      check("wr_err_load", wr_err, 0);
      if (i < len - 1) check("ready_during_load", wf_read_ready, 0);
    end
    ref_len = len;
    check("wf_len", wf_len, len);
    check("ready_loaded", wf_read_ready, 1);
  endtask

  task automatic play_run(input int rdy_pct, input int abort_after, input bit wr_in_play,
                          input bit wr_with_req, input int lp);
    int  c, hs;
    bit  done, aborted;
    logic [W-1:0] beat;
    build_expect(lp);
    check("ready_pre_play", wf_read_ready, 1);
    play_req = 1'b1; loop_cnt = 8'(lp);
    if (wr_with_req) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = $urandom; wr_last = 1'b1;
    end
    @(negedge axi_tclk);
    play_req = 1'b0; wr_en = 1'b0; wr_last = 1'b0;
    check("playing", playing, 1);
    check("wr_err_with_req", wr_err, wr_with_req);
    c = 1; hs = 0; done = 0; aborted = 0;
    while (!done && c < 20000) begin
      if (c == 1) check("tvalid_c1", wfrm_axis_tvalid, 0);
      if (c == 2) check("tvalid_c2", wfrm_axis_tvalid, 1);
      if (c > 2 && rdy_pct == 100) check("tvalid_cont", wfrm_axis_tvalid, 1);
      check("play_done_idle", play_done, 0);
      wfrm_axis_tready = ($urandom_range(99) < rdy_pct);
      if (wr_in_play && c == 3) begin
        wr_en = 1'b1; wr_addr = ADDR_W'($urandom_range(15)); wr_data = $urandom; wr_last = 1'b0;
      end
      if (abort_after >= 0 && hs == abort_after) begin
        abort = 1'b1; wfrm_axis_tready = 1'b0; aborted = 1;
      end
      if (wfrm_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
          done = 1;
        end else begin
          check("beat", {wfrm_axis_tlast, wfrm_axis_tdata}, exp_q[0]);
          if (wfrm_axis_tready) begin
            beat = exp_q.pop_front();
            hs++;
            if (beat[32]) done = 1;
          end
        end
      end
      if (aborted) done = 1;
      @(negedge axi_tclk);
      wr_en = 1'b0; abort = 1'b0;
      if (wr_in_play && c == 3) check("wr_err_in_play", wr_err, 1);
      c++;
    end
    wfrm_axis_tready = 1'b0;
    if (!done) check("play_timeout", 0, 1);
    check("play_done", play_done, 1);
    check("ready_post", wf_read_ready, 1);
    check("playing_post", playing, 0);
    check("tvalid_post", wfrm_axis_tvalid, 0);
    check("state_post", dbg_state, 2);
    if (!aborted) check("beats_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge axi_tclk);
    check("play_done_pulse", play_done, 0);
    check("tvalid_idle", wfrm_axis_tvalid, 0);
  endtask

  initial begin
    int len, pct, lp;
    axi_treset = 1'b1;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_last = 0; play_req = 0; abort = 0;
    loop_cnt = '0; wfrm_axis_tready = 0; ref_len = 0;
    repeat (2) @(negedge axi_tclk);
    check("rst_state", dbg_state, 0);
    check("rst_wf_len", wf_len, 0);
    check("rst_ready", wf_read_ready, 0);
    check("rst_tvalid", wfrm_axis_tvalid, 0);
    check("rst_tdata", wfrm_axis_tdata, 0);
    check("rst_tlast", wfrm_axis_tlast, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_play_done", play_done, 0);
    axi_treset = 1'b0;
    @(negedge axi_tclk);

    // Ramp waveform at full rate, then under random backpressure.
    load_wave(8, 1);
    play_run(100, -1, 0, 0, 0);
    play_run(50, -1, 0, 0, 0);

    // Single-sample waveform.
    load_wave(1, 0);
    play_run(100, -1, 0, 0, 0);

    // Abort after the third handshake, then a full replay.
    load_wave(16, 0);
    play_run(100, 3, 0, 0, 0);
    play_run(100, -1, 0, 0, 0);

    // Dropped writes: during playback and alongside the play request; replay shows RAM intact.
    play_run(70, -1, 1, 0, 0);
    play_run(100, -1, 0, 1, 0);
    play_run(100, -1, 0, 0, 0);

    // Abort outside PLAY is ignored.
    abort = 1'b1;
    @(negedge axi_tclk);
    abort = 1'b0;
    check("abort_idle_state", dbg_state, 2);
    check("abort_idle_done", play_done, 0);

    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(2, 24);
      pct = $urandom_range(30, 100);
`ifdef WFRM_LOOP_EN
      lp = $urandom_range(0, 3);
`else
      lp = 0;
`endif
      load_wave(len, 0);
      play_run(pct, -1, 0, 0, lp);
    end

`ifdef WFRM_LOOP_EN
    load_wave(4, 0);
    play_run(100, -1, 0, 0, 2);
    play_run(60, 5, 0, 0, 2);
`endif

    // Reset in the middle of playback.
    load_wave(10, 0);
    play_req = 1'b1;
    @(negedge axi_tclk);
    play_req = 1'b0;
    repeat (3) @(negedge axi_tclk);
    check("tvalid_before_rst", wfrm_axis_tvalid, 1);
    #2 axi_treset = 1'b1;
    #1;
    check("rst_mid_tvalid", wfrm_axis_tvalid, 0);
    check("rst_mid_playing", playing, 0);
    check("rst_mid_wf_len", wf_len, 0);
    check("rst_mid_state", dbg_state, 0);
    @(negedge axi_tclk);
    axi_treset = 1'b0;
    ref_len = 0;
    @(negedge axi_tclk);
    check("rst_mid_ready", wf_read_ready, 0);

    // Full-depth waveform: wf_len must reach DEPTH without wrapping.
    load_wave(DEPTH, 0);
    play_run(80, -1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
